// File: rtl/layer2_sequencer.sv
// Sequences one layer-2 pass over the 10-lane MAC array: bias load, accumulator clear,
// gated activation/weight stream from the synchronous buffers, then a done pulse.
`ifndef LAYER_2_WEIGHTS_BIT_WIDTH
`define LAYER_2_WEIGHTS_BIT_WIDTH 8
`endif

module layer2_sequencer #(
   parameter int NUM_INPUTS   = 64,
   parameter int ADDR_WIDTH   = 6,
   parameter int WEIGHT_WIDTH = `LAYER_2_WEIGHTS_BIT_WIDTH
) (
   input  logic                        clk,
   input  logic                        clr,
   input  logic                        start,
   input  logic [ADDR_WIDTH:0]         inCount,
   input  logic [10*WEIGHT_WIDTH-1:0]  weightsRom,
   output logic [ADDR_WIDTH-1:0]       rdAddr,
   output logic                        rdEn,
   output logic [10*WEIGHT_WIDTH-1:0]  weightsOut,
   output logic                        biasWriteEnable,
   output logic                        macClr,
   output logic                        busy,
   output logic                        done
);

   typedef enum logic [2:0] {IDLE, LOAD_BIAS, CLEAR, ACCUM, DRAIN, DONE} state_t;

   localparam logic [ADDR_WIDTH:0]   COUNT_MAX = (ADDR_WIDTH+1)'(NUM_INPUTS);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_INPUTS - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rdAddr_q, rdAddr_d;
   logic                  readValid_q;
   logic [ADDR_WIDTH:0]   effCount;
   logic                  avail;

   // Counts beyond the pass length are clamped so the last row is never overrun.
   assign effCount = (inCount > COUNT_MAX) ? COUNT_MAX : inCount;
   assign avail    = ({1'b0, rdAddr_q} < effCount);

   always_comb begin
      state_d         = state_q;
      rdAddr_d        = rdAddr_q;
      rdEn            = 1'b0;
      biasWriteEnable = 1'b0;
      macClr          = 1'b0;
      busy            = 1'b0;
      done            = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = LOAD_BIAS;
         end
         LOAD_BIAS: begin
            busy            = 1'b1;
            biasWriteEnable = 1'b1;
            state_d         = CLEAR;
         end
         CLEAR: begin
            busy     = 1'b1;
            macClr   = 1'b1;
            rdAddr_d = '0;
            state_d  = ACCUM;
         end
         ACCUM: begin
            busy = 1'b1;
            if (avail) begin
               rdEn = 1'b1;
               if (rdAddr_q == LAST_ADDR) begin
                  rdAddr_d = '0;
                  state_d  = DRAIN;
               end else begin
                  rdAddr_d = rdAddr_q + ADDR_WIDTH'(1);
               end
            end
         end
         DRAIN: begin
            busy    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= IDLE;
         rdAddr_q    <= '0;
         readValid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdAddr_q    <= rdAddr_d;
         readValid_q <= rdEn;
      end
   end

   // The MAC accumulates every edge, so anything but a returning read must present zero weight.
   assign weightsOut = readValid_q ? weightsRom : '0;
   assign rdAddr     = rdAddr_q;

`ifndef SYNTHESIS
   a_count_monotonic: assert property (@(posedge clk) disable iff (clr)
      (busy && $past(busy)) |-> (inCount >= $past(inCount)))
      else $error("inCount decreased during a pass");
`endif

endmodule

// File: tb/tb_layer2_sequencer.sv
// Bench for layer2_sequencer: memories and MAC array modelled around the DUT, sums and
// timing predicted from the pass rules with plain arithmetic.
module tb_layer2_sequencer;

   localparam int NI    = 4;
   localparam int AW    = 3;
   localparam int WW    = 8;
   localparam int LANES = 10;

   logic                  clk = 1'b0;
   logic                  clr, start;
   logic [AW:0]           inCount;
   logic [LANES*WW-1:0]   weightsRom, weightsOut;
   logic [AW-1:0]         rdAddr;
   logic                  rdEn, biasWriteEnable, macClr, busy, done;

   layer2_sequencer #(.NUM_INPUTS(NI), .ADDR_WIDTH(AW), .WEIGHT_WIDTH(WW)) dut (
      .clk(clk), .clr(clr), .start(start), .inCount(inCount), .weightsRom(weightsRom),
      .rdAddr(rdAddr), .rdEn(rdEn), .weightsOut(weightsOut),
      .biasWriteEnable(biasWriteEnable), .macClr(macClr), .busy(busy), .done(done));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string tag, input logic signed [127:0] obs,
                      input logic signed [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Environment: activation buffer, weight ROM, MAC array
   int act [NI];
   int wt  [LANES][NI];
   int bias [LANES];
   int biasReg [LANES];
   int sums [LANES];
   int actQ = 0;

   function automatic logic [LANES*WW-1:0] rom_word(input int a);
      logic [LANES*WW-1:0] v;
      v = '0;
      if (a < NI)
         for (int l = 0; l < LANES; l++) v[l*WW +: WW] = WW'(wt[l][a]);
      return v;
   endfunction

   function automatic int act_at(input int a);
      return (a < NI) ? act[a] : 0;
   endfunction

   function automatic int lane_w(input logic [LANES*WW-1:0] v, input int l);
      logic signed [WW-1:0] s;
      s = v[l*WW +: WW];
      return int'(s);
   endfunction

   function automatic int exp_sum(input int l, input int upto);
      int s;
      s = bias[l];
      for (int i = 0; i < upto; i++) s += act[i] * wt[l][i];
      return s;
   endfunction

   always @(posedge clk) begin
      weightsRom <= rom_word(int'(rdAddr));
      actQ       <= act_at(int'(rdAddr));
      for (int l = 0; l < LANES; l++) begin
         if (biasWriteEnable) biasReg[l] <= bias[l];
         if (macClr) sums[l] <= biasReg[l];
         else        sums[l] <= sums[l] + actQ * lane_w(weightsOut, l);
      end
   end

   // Monitor, sampled on the falling edge
   logic        mon_en = 1'b0;
   logic        prevRdEn = 1'b0, prevClr = 1'b0;
   logic [AW-1:0] prevAddr = '0;
   int bweCyc = -1, clrCyc = -1, doneCyc = -1, doneCycPrev = -1, doneCnt = 0, expAddr = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("weightsOut", weightsOut,
             (prevRdEn && !prevClr) ? rom_word(int'(prevAddr)) : '0);
         if (biasWriteEnable) bweCyc = cyc;
         if (macClr) begin
            clrCyc  = cyc;
            expAddr = 0;
         end
         if (rdEn) begin
            chk("rdAddr order", rdAddr, expAddr);
            chk("rdEn in range", (int'(rdAddr) < ((int'(inCount) > NI) ? NI : int'(inCount))), 1);
            expAddr++;
         end
         if (done) begin
            chk("busy low at done", busy, 0);
            doneCycPrev = doneCyc;
            doneCyc     = cyc;
            doneCnt++;
         end
      end
      prevRdEn = rdEn;
      prevAddr = rdAddr;
      prevClr  = clr;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, " rdAddr"}, rdAddr, 0);
      chk({tag, " rdEn"}, rdEn, 0);
      chk({tag, " biasWriteEnable"}, biasWriteEnable, 0);
      chk({tag, " macClr"}, macClr, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " weightsOut"}, weightsOut, 0);
   endtask

   // One pass: inCount starts at c0 and is raised to cfinal at cycle S+rel.
   task automatic run_pass(input string tag, input int c0, input int rel, input int cfinal,
                           input bit pulse);
      int S, T, eff0, last, n0, part;
      S = cyc + 1;
      T = S + rel;
      eff0 = (c0 > NI) ? NI : c0;
      last = S + 2 + NI - 1;
      if (eff0 < NI && T + (NI - 1 - eff0) > last) last = T + NI - 1 - eff0;
      part = exp_sum(0, eff0);
      n0 = doneCnt;
      inCount = AW'(c0) ;
      inCount = (AW+1)'(c0);
      start = 1'b1;
      step();
      for (int k = 0; k < 300 && doneCnt == n0; k++) begin
         start = pulse && (cyc == S + 3 || cyc == S + 5);
         if (eff0 < NI && cyc == T - 1 && T - 1 >= S + 3 + eff0)
            chk({tag, " stall hold"}, sums[0], part);
         if (cyc >= T) inCount = (AW+1)'(cfinal);
         step();
      end
      start = 1'b0;
      chk({tag, " done seen"}, doneCnt - n0, 1);
      chk({tag, " bias write cycle"}, bweCyc, S);
      chk({tag, " mac clear cycle"}, clrCyc, S + 1);
      chk({tag, " done cycle"}, doneCyc, last + 2);
      chk({tag, " read count"}, expAddr, NI);
      for (int l = 0; l < LANES; l++) chk({tag, " sum"}, sums[l], exp_sum(l, NI));
      repeat (3) step();
      chk({tag, " sum hold"}, sums[0], exp_sum(0, NI));
      chk({tag, " single done"}, doneCnt - n0, 1);
      chk({tag, " idle busy"}, busy, 0);
      chk({tag, " rdAddr wrapped"}, rdAddr, 0);
   endtask

   task automatic rand_data();
      for (int i = 0; i < NI; i++) act[i] = int'($urandom_range(0, 200)) - 100;
      for (int l = 0; l < LANES; l++) begin
         bias[l] = int'($urandom_range(0, 2000)) - 1000;
         for (int i = 0; i < NI; i++) wt[l][i] = int'($urandom_range(0, 255)) - 128;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int found, n0, s1, c0, rel, cf;
      clr = 1'b1; start = 1'b0; inCount = '0;
      for (int i = 0; i < NI; i++) act[i] = 0;
      for (int l = 0; l < LANES; l++) begin
         bias[l] = 0;
         for (int i = 0; i < NI; i++) wt[l][i] = 0;
      end
      repeat (3) step();
      check_idle_outputs("reset");
      clr = 1'b0;
      mon_en = 1'b1;
      step();

      // Basic pass: unit weights, activations 1..4, zero bias
      for (int i = 0; i < NI; i++) act[i] = i + 1;
      for (int l = 0; l < LANES; l++) begin
         bias[l] = 0;
         for (int i = 0; i < NI; i++) wt[l][i] = 1;
      end
      run_pass("basic", NI, 0, NI, 1'b0);
      chk("basic lane9 = 10", sums[9], 10);

      // Stall: two rows available, the rest arrive 10 cycles into the pass
      run_pass("stall", 2, 10, NI, 1'b0);
      chk("stall lane0 = 10", sums[0], 10);

      // Signed bias and weights on lane 0
      bias[0] = -5;
      for (int i = 0; i < NI; i++) wt[0][i] = -1;
      run_pass("signed", NI, 0, NI, 1'b0);
      chk("signed lane0 = -15", sums[0], -15);

      // start pulses while busy are ignored
      rand_data();
      run_pass("busy start", NI, 0, NI, 1'b1);

      // Reset in the middle of ACCUM
      rand_data();
      inCount = (AW+1)'(NI);
      start = 1'b1;
      step();
      start = 1'b0;
      found = 0;
      for (int k = 0; k < 30 && found == 0; k++) begin
         if (rdEn && rdAddr == 2) found = 1;
         else step();
      end
      chk("reach addr 2", found, 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check_idle_outputs("abort");
      n0 = doneCnt;
      repeat (NI + 6) step();
      chk("no done after abort", doneCnt - n0, 0);
      run_pass("after abort", NI, 0, NI, 1'b0);

      // start held high: back-to-back passes, each re-cleared to the biases
      rand_data();
      inCount = (AW+1)'(NI);
      s1 = cyc + 1;
      n0 = doneCnt;
      start = 1'b1;
      step();
      for (int k = 0; k < 300 && doneCnt < n0 + 2; k++) begin
         if (bweCyc > s1) start = 1'b0;
         step();
      end
      start = 1'b0;
      chk("b2b done count", doneCnt - n0, 2);
      chk("b2b first done", doneCycPrev, s1 + NI + 3);
      chk("b2b spacing", doneCyc - doneCycPrev, NI + 5);
      for (int l = 0; l < LANES; l++) chk("b2b sum", sums[l], exp_sum(l, NI));
      repeat (3) step();
      chk("b2b idle", busy, 0);

      // Randomized passes: data, initial count, raise time and over-range counts
      for (int p = 0; p < 10; p++) begin
         rand_data();
         c0  = int'($urandom_range(0, NI + 3));
         rel = int'($urandom_range(0, 12));
         cf  = int'($urandom_range((c0 > NI) ? c0 : NI, 15));
         run_pass("random", c0, rel, cf, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
